// File: rtl/adc_sample_fifo_pkg.sv
// rtl/adc_sample_fifo_pkg.sv - shared sizing constants for the ADC sample FIFO
// Holds the default sample width, address width, depth and occupancy-count width.
package adc_sample_fifo_pkg;

    localparam int ADC_DW    = 8;
    localparam int ADC_AW    = 4;
    localparam int ADC_DEPTH = 2 ** ADC_AW;
    // Occupancy runs 0..ADC_DEPTH inclusive, so one bit wider than the pointers.
    localparam int ADC_CW    = ADC_AW + 1;

endpackage

// File: rtl/strobe_sync_edge.sv
// rtl/strobe_sync_edge.sv - synchronizer plus rising-edge detector for slow strobes
// Ports:
//   clk    - destination clock
//   reset  - asynchronous, active-high reset
//   strobe - level strobe from a slower, unrelated clock domain
//   pulse  - one-cycle pulse per rising edge of strobe
module strobe_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability; s3 remembers the previous synchronized level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= strobe;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - 16-entry sample buffer between the ADC controller and the reply logic
// Optional feature macro: ADC_SAMPLE_FIFO_OVERWRITE_EN (write while full replaces the oldest entry).
// Ports:
//   clk, reset            - oscillator clock, asynchronous active-high reset
//   fifo_data/fifo_nextin - sample byte and its control-clock write strobe
//   rd_en                 - pop request; rd_data/rd_valid return the popped byte next cycle
//   count/empty/full      - occupancy and its decodes
//   overflow/ovf_clear    - sticky "sample arrived while full" flag and its clear
module adc_sample_fifo
    import adc_sample_fifo_pkg::*;
#(
    parameter int DW = ADC_DW,
    parameter int AW = ADC_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] fifo_data,
    input  logic          fifo_nextin,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    input  logic          ovf_clear
);

    localparam int        DEPTH    = 2 ** AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_pulse;
    logic          do_rd;
    logic          do_wr;
    logic          wr_full;
    logic          do_ovw;

    strobe_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .strobe (fifo_nextin),
        .pulse  (wr_pulse)
    );

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_rd   = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_wr   = wr_pulse & (~full | do_rd);
    assign wr_full = wr_pulse & full & ~do_rd;

`ifdef ADC_SAMPLE_FIFO_OVERWRITE_EN
    assign do_ovw = wr_full;
`else
    assign do_ovw = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= mem[rptr];
            end
            // Overwrite drops the oldest entry by advancing rptr alongside wptr.
            if (do_rd || do_ovw) begin
                rptr <= rptr + AW'(1);
            end
            if (do_wr || do_ovw) begin
                wptr <= wptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // Set has priority over clear so a coincident overflow is never lost.
            if (wr_full) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr || do_ovw) begin
            mem[wptr] <= fifo_data;
        end
    end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb/tb_adc_sample_fifo.sv - self-checking bench for adc_sample_fifo
module tb_adc_sample_fifo;
    import adc_sample_fifo_pkg::*;

    localparam int DW    = ADC_DW;
    localparam int AW    = ADC_AW;
    localparam int DEPTH = ADC_DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] fifo_data;
    logic          fifo_nextin;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          ovf_clear;

    adc_sample_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_data   (fifo_data),
        .fifo_nextin (fifo_nextin),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .ovf_clear   (ovf_clear)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q [$];
    logic          model_ovf;
    logic [DW-1:0] last_data;

    typedef struct {
        logic [DW-1:0] data;
        int            exp_count;
        bit            exp_full;
        bit            exp_ovf;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour of one accepted write strobe, after any coincident pop.
    task automatic model_write(input logic [DW-1:0] d, input bit clr);
        if (model_q.size() < DEPTH) begin
            model_q.push_back(d);
            if (clr) model_ovf = 1'b0;
        end else begin
            model_ovf = 1'b1;
`ifdef ADC_SAMPLE_FIFO_OVERWRITE_EN
            void'(model_q.pop_front());
            model_q.push_back(d);
`endif
        end
    endtask

    task automatic write_sample(input logic [DW-1:0] d);
        @(posedge clk); #1;
        fifo_data   = d;
        fifo_nextin = 1'b1;
        repeat (10) @(posedge clk);
        #1 fifo_nextin = 1'b0;
        repeat (4) @(posedge clk);
        model_write(d, 1'b0);
        @(negedge clk);
    endtask

    task automatic pop_check(input string name);
        logic [DW-1:0] e;
        bit            has;
        has = (model_q.size() > 0);
        e   = last_data;
        if (has) e = model_q.pop_front();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        @(negedge clk);
        check({name, " valid"}, 32'(rd_valid), 32'(has));
        check({name, " data"}, 32'(rd_data), 32'(e));
        last_data = e;
        @(negedge clk);
        check({name, " valid_drop"}, 32'(rd_valid), 32'(0));
    endtask

    // Strobe a write and line up rd_en / ovf_clear with the cycle the write commits.
    task automatic write_with(input logic [DW-1:0] d, input bit do_pop, input bit do_clr,
                              input string name);
        logic [DW-1:0] e;
        bit            has;
        @(posedge clk); #1;
        fifo_data   = d;
        fifo_nextin = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rd_en     = do_pop;
        ovf_clear = do_clr;
        @(posedge clk); #1;
        rd_en     = 1'b0;
        ovf_clear = 1'b0;
        has = do_pop && (model_q.size() > 0);
        e   = last_data;
        if (has) e = model_q.pop_front();
        model_write(d, do_clr);
        @(negedge clk);
        check({name, " valid"}, 32'(rd_valid), 32'(has));
        check({name, " data"}, 32'(rd_data), 32'(e));
        check({name, " count"}, 32'(count), 32'(model_q.size()));
        check({name, " ovf"}, 32'(overflow), 32'(model_ovf));
        last_data = e;
        repeat (8) @(posedge clk);
        #1 fifo_nextin = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " count"}, 32'(count), 32'(0));
        check({name, " empty"}, 32'(empty), 32'(1));
        check({name, " full"}, 32'(full), 32'(0));
        check({name, " ovf"}, 32'(overflow), 32'(0));
        check({name, " valid"}, 32'(rd_valid), 32'(0));
        check({name, " data"}, 32'(rd_data), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{data: DW'(i), exp_count: i + 1, exp_full: (i == 15), exp_ovf: 1'b0};
        end
        vecs[16] = '{data: 8'hFF, exp_count: 16, exp_full: 1'b1, exp_ovf: 1'b1};

        reset       = 1'b1;
        fifo_data   = '0;
        fifo_nextin = 1'b0;
        rd_en       = 1'b0;
        ovf_clear   = 1'b0;
        model_ovf   = 1'b0;
        last_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Single write: count rises exactly on the third edge after the strobe edge.
        @(posedge clk); #1;
        fifo_data   = 8'hA5;
        fifo_nextin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("latency_pre", 32'(count), 32'(0));
        end
        @(negedge clk);
        check("latency_edge3", 32'(count), 32'(1));
        repeat (12) @(posedge clk);
        #1 fifo_nextin = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("single_write_once", 32'(count), 32'(1));
        model_write(8'hA5, 1'b0);
        pop_check("pop_a5");
        check("empty_after_a5", 32'(empty), 32'(1));

        // Fill to full, then one overflowing write.
        for (int i = 0; i < 17; i++) begin
            write_sample(vecs[i].data);
            check($sformatf("fill%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("fill%0d full", i), 32'(full), 32'(vecs[i].exp_full));
            check($sformatf("fill%0d ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        @(posedge clk); #1 ovf_clear = 1'b1;
        @(posedge clk); #1 ovf_clear = 1'b0;
        @(negedge clk);
        check("ovf_clear", 32'(overflow), 32'(0));
        model_ovf = 1'b0;

        write_with(8'h55, 1'b1, 1'b0, "full_pop_write");
        check("full_pop_write full", 32'(full), 32'(1));
        write_with(8'hEE, 1'b0, 1'b1, "clr_vs_ovf");

        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("drain%0d", i));
        end
        check("drained empty", 32'(empty), 32'(1));
        pop_check("pop_empty");

        write_with(8'h77, 1'b1, 1'b0, "empty_pop_write");
        pop_check("pop_77");

        // Pointer wrap with occupancy kept at or below 3.
        for (int i = 0; i < 40; i++) begin
            write_sample(DW'(8'h20 + i));
            check($sformatf("wrap%0d occ", i), 32'(count <= 3), 32'(1));
            if (model_q.size() >= 3) pop_check($sformatf("wrap%0d pop", i));
        end
        while (model_q.size() > 0) pop_check("wrap_drain");

        // Reset mid-operation with a strobe in flight.
        for (int i = 0; i < 5; i++) write_sample(DW'(8'h60 + i));
        check("pre_reset count", 32'(count), 32'(5));
        @(posedge clk); #1;
        fifo_data   = 8'h99;
        fifo_nextin = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        fifo_nextin = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        last_data = '0;
        @(negedge clk);
        reset = 1'b0;
        write_sample(8'h3C);
        check("post_reset count", 32'(count), 32'(1));
        pop_check("pop_3c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
